// File: rtl/spectrum_pkg.sv
// spectrum_pkg
//   Shared constants, write-FSM state encoding and the magnitude helpers
//   used by the FFT spectrum feeder.
package spectrum_pkg;

  localparam int FFT_POINT = 256;  // bins per frame / bars per line
  localparam int ADDR_W    = 8;    // log2(FFT_POINT)
  localparam int V_ACT     = 720;  // active lines; heights saturate at V_ACT-1
  localparam int HGT_W     = 10;   // stored bar-height width

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_DONE = 2'd2
  } wr_state_e;

  // Two's-complement magnitude as unsigned; -32768 maps to 32768 (no wrap).
  function automatic logic [15:0] abs16(input logic [15:0] v);
    return v[15] ? (~v + 16'd1) : v;
  endfunction

  // Alpha-max-plus-half-beta-min magnitude estimate, scaled and saturated.
  function automatic logic [16:0] bar_height(input logic [15:0] a,
                                             input logic [15:0] b,
                                             input int          shift,
                                             input int          vmax);
    logic [16:0] mx;
    logic [16:0] mn;
    logic [16:0] h;
    mx = (a >= b) ? {1'b0, a} : {1'b0, b};
    mn = (a >= b) ? {1'b0, b} : {1'b0, a};
    h  = (mx + (mn >> 1)) >> shift;
    if (h > 17'(vmax)) begin
      h = 17'(vmax);
    end
    return h;
  endfunction

endpackage

// File: rtl/spectrum_bank_ram.sv
// spectrum_bank_ram
//   Simple dual-port memory holding both ping-pong banks of bar heights.
//   Address is {bank, bin}. Contents are not reset.
// Ports:
//   clk_i    - clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address (registered read, one-cycle latency)
//   rdata_o  - read data
module spectrum_bank_ram #(
  parameter int AW = 9,
  parameter int DW = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/fft_spectrum_feeder.sv
// fft_spectrum_feeder
//   Captures complex FFT frames, converts each bin to a saturated bar
//   height and serves one bar per data_req from a ping-pong buffer.
// Ports:
//   pix_clk, rstn          - pixel clock, async active-low reset
//   fft_valid/last/re/im   - FFT output stream
//   vs_in                  - renderer vsync; rising edge swaps banks
//   data_req               - advance to next bar (saturates at last bar)
//   fft_point_done         - rewind bar index to 0 (wins over data_req)
//   fft_point_cnt          - current bar index
//   fft_data               - current bar height, 0 when empty/invalid
//   overrun                - sticky: a frame was dropped while one was pending
module fft_spectrum_feeder #(
  parameter int FFT_POINT = spectrum_pkg::FFT_POINT,
  parameter int ADDR_W    = spectrum_pkg::ADDR_W,
  parameter int V_ACT     = spectrum_pkg::V_ACT,
  parameter int MAG_SHIFT = 6,
  parameter int HGT_W     = spectrum_pkg::HGT_W
) (
  input  logic              pix_clk,
  input  logic              rstn,
  input  logic              fft_valid,
  input  logic              fft_last,
  input  logic [15:0]       fft_re,
  input  logic [15:0]       fft_im,
  input  logic              vs_in,
  input  logic              data_req,
  input  logic              fft_point_done,
  output logic [ADDR_W-1:0] fft_point_cnt,
  output logic [31:0]       fft_data,
  output logic              overrun
);
  import spectrum_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(FFT_POINT - 1);

  wr_state_e         state_q;
  logic              wr_bank_q, rd_bank_q, disp_valid_q, overrun_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W:0]   wr_len_q, rd_len_q;
  logic              vs_q, swap_req_q;

  logic              s1_valid_q, s2_valid_q;
  logic [15:0]       s1_a_q, s1_b_q;
  logic [ADDR_W-1:0] s1_addr_q, s2_addr_q;
  logic [HGT_W-1:0]  s2_hgt_q;
  logic [16:0]       hgt_full;

  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              rd_bank_d;
  logic [HGT_W-1:0]  ram_rdata;

  logic accept, frame_end, swap_ok;

  assign accept    = fft_valid && (state_q != W_DONE);
  assign frame_end = fft_last || (wr_addr_q == LAST_BIN);
  // The swap must not overtake the final write still travelling down the
  // magnitude pipeline; such a vsync edge is simply not honoured.
  assign swap_ok   = swap_req_q && (state_q == W_DONE) && !s1_valid_q && !s2_valid_q;
  assign hgt_full  = bar_height(s1_a_q, s1_b_q, MAG_SHIFT, V_ACT - 1);

  // Write FSM, bank ownership and sticky overrun.
  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= W_IDLE;
      wr_addr_q    <= '0;
      wr_len_q     <= '0;
      rd_len_q     <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b1;
      disp_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      case (state_q)
        W_IDLE, W_FILL: begin
          if (fft_valid) begin
            if (frame_end) begin
              wr_len_q  <= (ADDR_W+1)'(wr_addr_q) + (ADDR_W+1)'(1);
              wr_addr_q <= '0;
              state_q   <= W_DONE;
            end else begin
              wr_addr_q <= wr_addr_q + ADDR_W'(1);
              state_q   <= W_FILL;
            end
          end
        end
        W_DONE: begin
          if (fft_valid) begin
            overrun_q <= 1'b1;
          end
          if (swap_ok) begin
            state_q      <= W_IDLE;
            wr_bank_q    <= ~wr_bank_q;
            rd_bank_q    <= wr_bank_q;
            rd_len_q     <= wr_len_q;
            disp_valid_q <= 1'b1;
          end
        end
        default: state_q <= W_IDLE;
      endcase
    end
  end

  // Two-stage magnitude pipeline plus vsync edge detect.
  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_addr_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_hgt_q   <= '0;
      s2_addr_q  <= '0;
      vs_q       <= 1'b0;
      swap_req_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_a_q    <= abs16(fft_re);
        s1_b_q    <= abs16(fft_im);
        s1_addr_q <= wr_addr_q;
      end
      s2_valid_q <= s1_valid_q;
      s2_hgt_q   <= hgt_full[HGT_W-1:0];
      s2_addr_q  <= s1_addr_q;
      vs_q       <= vs_in;
      swap_req_q <= vs_in && !vs_q;
    end
  end

  // Next bar index drives the RAM directly so index and data move together.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (fft_point_done) begin
      rd_cnt_d = '0;
    end else if (data_req && (rd_cnt_q != LAST_BIN)) begin
      rd_cnt_d = rd_cnt_q + ADDR_W'(1);
    end
  end

  assign rd_bank_d = swap_ok ? wr_bank_q : rd_bank_q;

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      rd_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
    end
  end

  spectrum_bank_ram #(
    .AW (ADDR_W + 1),
    .DW (HGT_W)
  ) u_ram (
    .clk_i   (pix_clk),
    .we_i    (s2_valid_q),
    .waddr_i ({wr_bank_q, s2_addr_q}),
    .wdata_i (s2_hgt_q),
    .raddr_i ({rd_bank_d, rd_cnt_d}),
    .rdata_o (ram_rdata)
  );

  assign fft_point_cnt = rd_cnt_q;
  assign fft_data      = (disp_valid_q && ((ADDR_W+1)'(rd_cnt_q) < rd_len_q))
                         ? 32'(ram_rdata) : 32'd0;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_fft_spectrum_feeder.sv
module tb_fft_spectrum_feeder;

  localparam int NPT  = 256;
  localparam int VMAX = 719;

  logic        pix_clk = 1'b0;
  logic        rstn = 1'b0;
  logic        fft_valid = 1'b0;
  logic        fft_last = 1'b0;
  logic [15:0] fft_re = '0;
  logic [15:0] fft_im = '0;
  logic        vs_in = 1'b0;
  logic        data_req = 1'b0;
  logic        fft_point_done = 1'b0;
  logic [7:0]  fft_point_cnt;
  logic [31:0] fft_data;
  logic        overrun;

  always #5 pix_clk = ~pix_clk;

  fft_spectrum_feeder dut (
    .pix_clk        (pix_clk),
    .rstn           (rstn),
    .fft_valid      (fft_valid),
    .fft_last       (fft_last),
    .fft_re         (fft_re),
    .fft_im         (fft_im),
    .vs_in          (vs_in),
    .data_req       (data_req),
    .fft_point_done (fft_point_done),
    .fft_point_cnt  (fft_point_cnt),
    .fft_data       (fft_data),
    .overrun        (overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a frame being collected, a pending complete frame,
  // and the frame currently on display.
  int  m_wr[NPT];
  int  m_wr_cnt;
  bit  m_pending;
  int  m_pend_len;
  int  m_disp[NPT];
  int  m_disp_len;
  bit  m_disp_valid;
  bit  m_overrun;
  int  m_idx;

  logic [15:0] fr_re[NPT];
  logic [15:0] fr_im[NPT];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_height(input logic [15:0] re, input logic [15:0] im);
    int ar, ai, mx, mn, h;
    ar = int'($signed(re));
    ai = int'($signed(im));
    if (ar < 0) ar = -ar;
    if (ai < 0) ai = -ai;
    mx = (ar > ai) ? ar : ai;
    mn = (ar > ai) ? ai : ar;
    h  = (mx + mn / 2) / 64;
    return (h > VMAX) ? VMAX : h;
  endfunction

  function automatic int exp_bar(input int idx);
    return (m_disp_valid && idx < m_disp_len) ? m_disp[idx] : 0;
  endfunction

  task automatic model_reset();
    m_wr_cnt     = 0;
    m_pending    = 0;
    m_pend_len   = 0;
    m_disp_len   = 0;
    m_disp_valid = 0;
    m_overrun    = 0;
    m_idx        = 0;
  endtask

  task automatic model_sample(input logic [15:0] re, input logic [15:0] im, input bit last);
    if (m_pending) begin
      m_overrun = 1;
    end else begin
      m_wr[m_wr_cnt] = ref_height(re, im);
      m_wr_cnt++;
      if (last || m_wr_cnt == NPT) begin
        m_pending  = 1;
        m_pend_len = m_wr_cnt;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq($sformatf("%s_cnt%0d", tag, m_idx), 32'(fft_point_cnt), m_idx);
    check_eq($sformatf("%s_data%0d", tag, m_idx), fft_data, exp_bar(m_idx));
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NPT; i++) begin
      fr_re[i] = 16'(i * 64);
      fr_im[i] = 16'd0;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPT; i++) begin
      fr_re[i] = 16'($urandom);
      fr_im[i] = 16'($urandom);
    end
  endtask

  task automatic send_frame(input int n, input int last_at, input bit gaps);
    for (int i = 0; i < n; i++) begin
      @(negedge pix_clk);
      fft_valid = 1'b1;
      fft_re    = fr_re[i];
      fft_im    = fr_im[i];
      fft_last  = (i == last_at);
      model_sample(fr_re[i], fr_im[i], i == last_at);
      if (gaps && $urandom_range(3) == 0) begin
        @(negedge pix_clk);
        fft_valid = 1'b0;
        fft_last  = 1'b0;
      end
    end
    @(negedge pix_clk);
    fft_valid = 1'b0;
    fft_last  = 1'b0;
    repeat (4) @(negedge pix_clk);
    $display("frame: %0d samples sent, last_at=%0d", n, last_at);
  endtask

  task automatic vsync();
    @(negedge pix_clk);
    vs_in = 1'b1;
    repeat (3) @(negedge pix_clk);
    vs_in = 1'b0;
    repeat (2) @(negedge pix_clk);
    if (m_pending) begin
      for (int i = 0; i < NPT; i++) m_disp[i] = m_wr[i];
      m_disp_len   = m_pend_len;
      m_disp_valid = 1;
      m_pending    = 0;
      m_wr_cnt     = 0;
    end
    $display("vsync: disp_valid=%0d len=%0d", m_disp_valid, m_disp_len);
  endtask

  task automatic read_bars(input int n, input bit gaps);
    @(negedge pix_clk);
    fft_point_done = 1'b1;
    @(negedge pix_clk);
    fft_point_done = 1'b0;
    m_idx = 0;
    check_outputs("done");
    for (int k = 0; k < n; k++) begin
      data_req = 1'b1;
      @(negedge pix_clk);
      if (m_idx < NPT - 1) m_idx++;
      check_outputs("req");
      if (gaps && $urandom_range(4) == 0) begin
        data_req = 1'b0;
        @(negedge pix_clk);
        check_outputs("hold");
      end
    end
    data_req = 1'b0;
    $display("read: %0d requests, index now %0d", n, m_idx);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge pix_clk);
    rstn = 1'b1;
    @(negedge pix_clk);
    check_eq("reset_cnt", 32'(fft_point_cnt), 0);
    check_eq("reset_data", fft_data, 0);
    check_eq("reset_overrun", 32'(overrun), 0);

    // Full ramp frame: nothing shown before the swap, 0..255 after.
    fill_ramp();
    send_frame(NPT, -1, 1'b0);
    read_bars(NPT - 1, 1'b0);
    vsync();
    read_bars(NPT - 1, 1'b0);

    // Saturation and small-magnitude extremes.
    fr_re[0] = 16'h8000; fr_im[0] = 16'h8000;
    fr_re[1] = 16'd3;    fr_im[1] = 16'hfff8;
    send_frame(2, 1, 1'b0);
    vsync();
    read_bars(4, 1'b0);
    check_eq("sat_bar0", 32'(exp_bar(0)), 719);

    // Short frame whose last sample coincides with a vsync edge: that edge
    // lands while the write is in flight and is ignored; the next one swaps.
    fill_random();
    for (int i = 0; i < 10; i++) begin
      @(negedge pix_clk);
      fft_valid = 1'b1;
      fft_re    = fr_re[i];
      fft_im    = fr_im[i];
      fft_last  = (i == 9);
      vs_in     = (i == 9);
      model_sample(fr_re[i], fr_im[i], i == 9);
    end
    @(negedge pix_clk);
    fft_valid = 1'b0;
    fft_last  = 1'b0;
    repeat (3) @(negedge pix_clk);
    vs_in = 1'b0;
    repeat (3) @(negedge pix_clk);
    $display("frame: 10 samples with vsync on last sample");
    read_bars(3, 1'b0);
    vsync();
    read_bars(NPT - 1, 1'b1);

    // Random full frame with gaps in the input stream.
    fill_random();
    send_frame(NPT, -1, 1'b1);
    vsync();
    read_bars(NPT - 1, 1'b1);

    // Index control: done beats a simultaneous request; index saturates.
    read_bars(20, 1'b0);
    @(negedge pix_clk);
    data_req       = 1'b1;
    fft_point_done = 1'b1;
    @(negedge pix_clk);
    data_req       = 1'b0;
    fft_point_done = 1'b0;
    m_idx = 0;
    check_outputs("done_wins");
    read_bars(300, 1'b0);

    // Overrun: second frame dropped, first displayed, third accepted.
    check_eq("pre_overrun", 32'(overrun), 32'(m_overrun));
    fill_random();
    send_frame(NPT, -1, 1'b0);
    fill_random();
    send_frame(NPT, -1, 1'b0);
    check_eq("overrun_set", 32'(overrun), 32'(m_overrun));
    vsync();
    read_bars(NPT - 1, 1'b0);
    fill_random();
    send_frame(NPT, -1, 1'b0);
    vsync();
    read_bars(NPT - 1, 1'b0);
    check_eq("overrun_sticky", 32'(overrun), 32'(m_overrun));

    // Reset in the middle of a frame.
    fill_random();
    send_frame(100, -1, 1'b0);
    @(negedge pix_clk);
    rstn = 1'b0;
    #1;
    model_reset();
    check_eq("midreset_cnt", 32'(fft_point_cnt), 0);
    check_eq("midreset_data", fft_data, 0);
    check_eq("midreset_overrun", 32'(overrun), 0);
    @(negedge pix_clk);
    rstn = 1'b1;
    $display("reset: asserted after 100 bins");
    vsync();
    read_bars(NPT - 1, 1'b0);
    fill_random();
    send_frame(NPT, -1, 1'b0);
    vsync();
    read_bars(NPT - 1, 1'b0);
    check_eq("final_overrun", 32'(overrun), 32'(m_overrun));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fft_spectrum_feeder.md
# fft_spectrum_feeder

Supplies per-bar magnitude values to the HDMI spectrum renderer. Captures complex FFT output frames, converts each bin to a scaled, saturated bar height, and stores them in a ping-pong buffer. Serves one bar value per `data_req` pulse during each active line. Sits between the FFT core output (already in the `pix_clk` domain) and the spectrum pattern generator, which it drives through `fft_point_cnt`/`fft_data`.

## Interface
- `FFT_POINT`, 256: bins per frame and bars per line; power of two.
- `ADDR_W`, 8: log2(FFT_POINT).
- `V_ACT`, 720: active lines; bar height saturates at V_ACT-1.
- `MAG_SHIFT`, 6: right shift applied to the magnitude before saturation.
- `HGT_W`, 10: stored bar-height width; must satisfy 2^HGT_W > V_ACT-1.

Ports:
- `pix_clk` in 1: pixel clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `fft_valid` in 1: FFT sample valid.
- `fft_last` in 1: last bin of the frame; qualified by `fft_valid`.
- `fft_re` in 16: signed real part.
- `fft_im` in 16: signed imaginary part.
- `vs_in` in 1: renderer vertical sync; rising edge is the bank-swap point.
- `data_req` in 1: one-cycle pulse requesting the next bar.
- `fft_point_done` in 1: end-of-active-line pulse; rewinds the bar index.
- `fft_point_cnt` out ADDR_W: current bar index.
- `fft_data` out 32: height of the current bar, zero-extended.
- `overrun` out 1: sticky flag; a frame was dropped because the previous frame had not yet been displayed.

## Operation
- **Magnitude pipeline (2 stages).**
  - Stage 1: compute `a=|re|`, `b=|im|` as 16-bit unsigned. |-32768| = 32768, with no wrap.
  - Stage 2: `mag = max(a,b) + (min(a,b)>>1)`, 17 bits. Then `h = mag>>MAG_SHIFT`, saturated to V_ACT-1.
  - Valid, last and the bin address travel with the data.
- **Write FSM.** States W_IDLE, W_FILL, W_DONE.
  - W_IDLE: the first `fft_valid` writes bin 0 and moves to W_FILL. If that sample also carries `fft_last`, go directly to W_DONE with length 1.
  - W_FILL: `wr_addr` increments per valid. Complete when a valid arrives with `wr_addr==FFT_POINT-1` or with `fft_last`. On completion, latch `wr_len = wr_addr+1` and go to W_DONE (pending).
  - W_DONE: all valids are dropped. Any dropped valid sets `overrun`.
  - W_DONE→W_IDLE happens at the bank swap.
- **Bank swap.**
  - On a `vs_in` rising edge while in W_DONE: `rd_bank <= wr_bank`, `wr_bank` toggles, `rd_len <= wr_len`, `disp_valid <= 1`.
  - A `vs_in` rising edge outside W_DONE does nothing.
- **Read side.**
  - `fft_point_done` sets `rd_cnt <= 0`.
  - Otherwise `data_req` increments `rd_cnt`, saturating at FFT_POINT-1.
  - If both arrive in the same cycle, `fft_point_done` wins.
- **RAM read.** The read address is the next value of `rd_cnt`, presented combinationally to the synchronous RAM. As a result, `fft_point_cnt` and `fft_data` update on the same edge.
- **`fft_data` is 0** when `disp_valid==0` or when `fft_point_cnt >= rd_len`. The renderer treats 0 as an empty bar.
- **Reset values:**
  - `fft_point_cnt=0`, `fft_data=0`, `overrun=0`.
  - FSM in W_IDLE, `wr_bank=0`, `rd_bank=1`.
  - `disp_valid=0`, `rd_len=0`, `wr_len=0`, `wr_addr=0`.
  - RAM contents are not reset; `disp_valid` masks them.
- **Reset mid-frame:** the partial frame is discarded. The next `fft_valid` starts at bin 0.

## Timing
- Input sample to RAM write: 2 cycles after the `fft_valid` edge. A swap edge is registered 1 cycle after `vs_in` rises (edge detect).
- A swap is honoured only once the final pipeline write has landed. If a `vs_in` edge arrives while the last write is still in flight, the swap waits for the next `vs_in` edge.
- `data_req` sampled at edge N → `fft_point_cnt`/`fft_data` valid after edge N+1.
- `fft_point_done` at edge N → index 0 and bin-0 data after edge N+1.
- Back-to-back `data_req` pulses are supported (one bar per cycle).
- Write and read ports are always in different banks, so there is no read-during-write hazard.

## Structure
- Package `spectrum_pkg`: FFT_POINT, ADDR_W, HGT_W, V_ACT, the write-FSM state encoding, and the magnitude/saturation function.
- Sub-module `spectrum_bank_ram`: simple dual-port memory, 2·FFT_POINT × HGT_W. One write port, one synchronous read port. Address = {bank, bin}.

## Test plan
- **Full frame and display.** Send 256 bins with re=bin·64, im=0, MAG_SHIFT=6, then a `vs_in` rise. Then pulse `data_req` 255 times. Expect `fft_data` 0,1,…,255 and `fft_point_cnt` 0…255. Before the swap, all values are 0.
- **Saturation and extremes.** Send re=−32768, im=−32768 (mag=49152, >>6 = 768). Expect 719. Send re=3, im=−8 (mag=9, >>6 = 0). Expect 0.
- **Short frame.** Send 10 bins with `fft_last` on bin 9, then swap. Expect bins 0–9 to show values and bins 10–255 to show 0.
- **Overrun.** Send two full frames with no `vs_in` between them. Expect `overrun=1` and the first frame displayed after the swap. The third frame, arriving after the swap, is accepted.
- **Index control.** Assert `data_req` and `fft_point_done` in the same cycle. Expect `fft_point_cnt=0`. Send 300 `data_req` pulses without a done: the index holds at 255.
- **Reset mid-frame.** Deassert `rstn` after 100 bins. Expect all outputs at their reset values and `disp_valid=0`. A fresh full frame then displays correctly.
